raga_timer: RTL and testbench

RAGA_TIMER -- requirements
Module: raga_timer

---
 rtl/raga_timer_if.sv | 24 ++
 rtl/raga_timer.sv | 93 +++++++++
 tb/tb_raga_timer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/raga_timer_if.sv
// Control/status bundle of the irrigation timer: operator inputs in, valve drive and BCD readout out.
interface raga_timer_if;
  logic       Load;
  logic [3:0] TensIn;
  logic [3:0] UnitsIn;
  logic       Start;
  logic       Stop;
  logic       Wet;
  logic       Valve;
  logic       Done;
  logic [3:0] Tens;
  logic [3:0] Units;
  logic       Busy;

  modport slave (
    input  Load, TensIn, UnitsIn, Start, Stop, Wet,
    output Valve, Done, Tens, Units, Busy
  );

  modport master (
    output Load, TensIn, UnitsIn, Start, Stop, Wet,
    input  Valve, Done, Tens, Units, Busy
  );
endinterface

// File: rtl/raga_timer.sv
// Irrigation countdown timer: two-digit BCD duration, DIV-cycle prescaled ticks,
// manual/wet-soil abort with resume, one-cycle Done pulse on natural completion.
module raga_timer #(
  parameter int unsigned DIV = 50000000
) (
  input  logic         Clk,
  input  logic         Rst,
  raga_timer_if.slave  bus
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        r_state, w_next;
  logic [PW-1:0] r_presc, w_presc;
  logic [3:0]    r_tens, r_units, w_tens, w_units;
  logic          r_valve, r_busy, r_done;
  logic          w_nonzero, w_tick, w_last;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign w_nonzero = (r_tens != '0) || (r_units != '0);
  assign w_tick    = (r_presc == PW'(DIV - 1));
  assign w_last    = (r_tens == '0) && (r_units <= 4'd1);

  always_comb begin
    w_next  = r_state;
    w_presc = r_presc;
    w_tens  = r_tens;
    w_units = r_units;
    case (r_state)
      IDLE: begin
        if (bus.Load) begin
          w_tens  = clamp9(bus.TensIn);
          w_units = clamp9(bus.UnitsIn);
        end else if (bus.Start && !bus.Wet && w_nonzero) begin
          w_next  = RUN;
          w_presc = '0;
        end
      end
      RUN: begin
        // abort outranks a coinciding tick, so the remaining time is left untouched
        if (bus.Stop || bus.Wet) begin
          w_next = IDLE;
        end else if (w_tick) begin
          w_presc = '0;
          if (r_units != '0) begin
            w_units = r_units - 4'd1;
          end else if (r_tens != '0) begin
            w_units = 4'd9;
            w_tens  = r_tens - 4'd1;
          end
          if (w_last) w_next = FIN;
        end else begin
          w_presc = r_presc + PW'(1);
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_tens  <= '0;
      r_units <= '0;
      r_valve <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_presc <= w_presc;
      r_tens  <= w_tens;
      r_units <= w_units;
      // outputs registered from the next state so they track r_state without a decode glitch
      r_valve <= (w_next == RUN);
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == FIN);
    end
  end

  assign bus.Valve = r_valve;
  assign bus.Busy  = r_busy;
  assign bus.Done  = r_done;
  assign bus.Tens  = r_tens;
  assign bus.Units = r_units;

endmodule

// File: tb/tb_raga_timer.sv
// Directed bench for raga_timer (DIV=4) with an integer-seconds reference model checked every cycle.
module tb_raga_timer;

  localparam int DIV = 4;

  logic Clk;
  logic Rst;
  raga_timer_if bus();

  raga_timer #(.DIV(DIV)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: remaining time as a plain integer, run/finish flags, cycles since run start
  bit m_run = 1'b0;
  bit m_fin = 1'b0;
  int m_rem = 0;
  int m_cnt = 0;

  function automatic int min9(input logic [3:0] d);
    return (int'(d) > 9) ? 9 : int'(d);
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_run = 1'b0; m_fin = 1'b0; m_rem = 0; m_cnt = 0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (!m_run) begin
      if (bus.Load)
        m_rem = min9(bus.TensIn) * 10 + min9(bus.UnitsIn);
      else if (bus.Start && !bus.Wet && m_rem != 0) begin
        m_run = 1'b1; m_cnt = 0;
      end
    end else begin
      if (bus.Stop || bus.Wet) m_run = 1'b0;
      else begin
        m_cnt++;
        if (m_cnt % DIV == 0) begin
          m_rem--;
          if (m_rem == 0) begin m_run = 1'b0; m_fin = 1'b1; end
        end
      end
    end
  end

  always @(negedge Clk) begin
    chk("valve", int'(bus.Valve), int'(m_run));
    chk("busy",  int'(bus.Busy),  int'(m_run));
    chk("done",  int'(bus.Done),  int'(m_fin));
    chk("tens",  int'(bus.Tens),  m_rem / 10);
    chk("units", int'(bus.Units), m_rem % 10);
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic load(input int t, input int u);
    bus.Load = 1'b1; bus.TensIn = 4'(t); bus.UnitsIn = 4'(u);
    step(1);
    bus.Load = 1'b0;
  endtask

  task automatic start();
    bus.Start = 1'b1;
    step(1);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (k < 200) begin
      step(1);
      k++;
      if (bus.Done) break;
    end
  endtask

  int k;

  initial begin
    Rst = 1'b1;
    bus.Load = 1'b0; bus.TensIn = '0; bus.UnitsIn = '0;
    bus.Start = 1'b0; bus.Stop = 1'b0; bus.Wet = 1'b0;
    #1 Rst = 1'b0;
    step(2);
    chk("rst_valve", int'(bus.Valve), 0);
    chk("rst_tens",  int'(bus.Tens),  0);
    chk("rst_units", int'(bus.Units), 0);
    chk("rst_done",  int'(bus.Done),  0);
    #2 Rst = 1'b1;
    step(1);

    // 12 -> 00, done at the 12th tick
    load(1, 2);
    chk("ld12_tens", int'(bus.Tens), 1);
    chk("ld12_units", int'(bus.Units), 2);
    start();
    chk("t1_valve_next", int'(bus.Valve), 1);
    chk("t1_busy_next",  int'(bus.Busy), 1);
    step(4); chk("t1_tick1_units", int'(bus.Units), 1);
    step(4); chk("t1_tick2_units", int'(bus.Units), 0);
    step(4); chk("t1_tick3_tens", int'(bus.Tens), 0);
             chk("t1_tick3_units", int'(bus.Units), 9);
    wait_done(k);
    chk("t1_done_lat", k, 36);
    step(1);
    chk("t1_done_clear", int'(bus.Done), 0);
    chk("t1_valve_off", int'(bus.Valve), 0);

    // borrow path, Load ignored in RUN, then clamp
    load(1, 0);
    start();
    step(4);
    chk("t2_borrow_tens", int'(bus.Tens), 0);
    chk("t2_borrow_units", int'(bus.Units), 9);
    bus.Load = 1'b1; bus.TensIn = 4'd5; bus.UnitsIn = 4'd5;
    step(1);
    bus.Load = 1'b0;
    chk("t2_load_ignored", int'(bus.Units), 9);
    bus.Stop = 1'b1; step(1); bus.Stop = 1'b0;
    chk("t2_stop_valve", int'(bus.Valve), 0);
    load(12, 15);
    chk("t2_clamp_tens", int'(bus.Tens), 9);
    chk("t2_clamp_units", int'(bus.Units), 9);

    // wet abort holds remaining, resume finishes
    load(0, 5);
    start();
    step(8);
    bus.Wet = 1'b1; step(1);
    chk("t3_wet_valve", int'(bus.Valve), 0);
    chk("t3_wet_units", int'(bus.Units), 3);
    chk("t3_wet_done", int'(bus.Done), 0);
    bus.Wet = 1'b0;
    start();
    wait_done(k);
    chk("t3_resume_lat", k, 12);
    step(1);

    // stop on the tick cycle: no decrement
    load(0, 3);
    start();
    step(3);
    bus.Stop = 1'b1; step(1); bus.Stop = 1'b0;
    chk("t4_stop_tick_valve", int'(bus.Valve), 0);
    chk("t4_stop_tick_units", int'(bus.Units), 3);

    // zero duration, wet, and Start+Load together
    load(0, 0);
    start();
    chk("t5_zero_valve", int'(bus.Valve), 0);
    step(1);
    chk("t5_zero_done", int'(bus.Done), 0);
    load(0, 7);
    bus.Wet = 1'b1; start(); bus.Wet = 1'b0;
    chk("t5_wet_valve", int'(bus.Valve), 0);
    bus.Load = 1'b1; bus.TensIn = 4'd0; bus.UnitsIn = 4'd4; bus.Start = 1'b1;
    step(1);
    bus.Load = 1'b0; bus.Start = 1'b0;
    chk("t5_both_units", int'(bus.Units), 4);
    chk("t5_both_valve", int'(bus.Valve), 0);
    step(1);
    chk("t5_both_valve2", int'(bus.Valve), 0);

    // async reset between edges mid-run
    load(2, 0);
    start();
    step(5);
    #2 Rst = 1'b0;
    #1;
    chk("t6_async_valve", int'(bus.Valve), 0);
    chk("t6_async_busy", int'(bus.Busy), 0);
    chk("t6_async_tens", int'(bus.Tens), 0);
    chk("t6_async_units", int'(bus.Units), 0);
    step(1);
    #2 Rst = 1'b1;
    bus.Start = 1'b1;
    step(1);
    bus.Start = 1'b0;
    chk("t6_post_idle", int'(bus.Valve), 0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
